mult_accumulator: RTL and testbench

MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

---
 rtl/mult_accumulator.sv | 118 +++++++++++
 tb/tb_mult_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accumulator.sv
// Multiply-accumulate sequencer: sums a counted run of 32-bit products into a
// saturating ACC_W-bit accumulator, then holds the result until it is consumed.
module mult_accumulator #(
    parameter int ACC_W = 36,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             clear,
    output logic             mult_en,
    input  logic [31:0]      p,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             busy,
    output logic [LEN_W-1:0] beats_left,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    generate
        if (ACC_W < 33) begin : g_bad_width
            $error("mult_accumulator: ACC_W must be at least 33");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum_w;

    // State register and datapath registers; rst outranks everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // One extra bit so the carry out of the accumulator is visible.
    assign sum_w = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, p};

    // Next-state and next-datapath logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = length;
                        state_d = (length == '0) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (p_valid) begin
                        if (sum_w[ACC_W] || ovf_q) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_w[ACC_W-1:0];
                        end
                        cnt_d = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only; p_ready never sees p_valid.
    always_comb begin
        mult_en    = (state_q == S_ACC);
        p_ready    = (state_q == S_ACC);
        busy       = (state_q != S_IDLE);
        res_valid  = (state_q == S_DONE);
        beats_left = (state_q == S_ACC) ? cnt_q : '0;
        result     = acc_q;
        ovf        = ovf_q;
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Randomised bench for mult_accumulator: an unsaturated-sum reference model is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_mult_accumulator;

    localparam int ACC_W = 36;
    localparam int LEN_W = 8;
    localparam logic [63:0] MAXV = (64'd1 << ACC_W) - 64'd1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] length;
    logic             clear;
    logic             mult_en;
    logic [31:0]      p;
    logic             p_valid;
    logic             p_ready;
    logic             busy;
    logic [LEN_W-1:0] beats_left;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] result;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    mult_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length), .clear(clear),
        .mult_en(mult_en), .p(p), .p_valid(p_valid), .p_ready(p_ready),
        .busy(busy), .beats_left(beats_left), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input logic [63:0] s);
        return (s > MAXV) ? MAXV : s;
    endfunction

    // Reference model: phase 0 = idle, 1 = accumulating, 2 = result held.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [63:0] m_sum   = '0;
    bit          m_fresh = 1'b0;
    bit          m_live  = 1'b0;

    always @(posedge clk) begin
        if (rst || clear) begin
            m_phase <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_fresh <= 1'b1;
            if (rst) m_live <= 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_sum   <= '0;
                m_fresh <= 1'b0;
                m_left  <= int'(length);
                m_phase <= (length == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (p_valid) begin
                m_sum  <= m_sum + 64'(p);
                m_left <= m_left - 1;
                if (m_left == 1) m_phase <= 2;
            end
        end else begin
            if (res_ready) m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("p_ready", 64'(p_ready), 64'(m_phase == 1));
            chk("mult_en", 64'(mult_en), 64'(m_phase == 1));
            chk("res_valid", 64'(res_valid), 64'(m_phase == 2));
            chk("beats_left", 64'(beats_left), (m_phase == 1) ? 64'(m_left) : 64'd0);
            if (m_phase != 0 || m_fresh)
                chk("ovf", 64'(ovf), 64'(m_sum > MAXV));
            if (m_phase == 2 || (m_phase == 0 && m_fresh))
                chk("result", 64'(result), sat(m_sum));
        end
    end

    logic [31:0] beats[$];

    task automatic start_run(input int len);
        start  = 1'b1;
        length = LEN_W'(len);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic feed(input logic [31:0] v, input int maxgap);
        int gap;
        gap = int'($urandom_range(maxgap, 0));
        repeat (gap) begin
            p_valid = 1'b0;
            p       = $urandom;
            start   = 1'($urandom_range(1, 0));
            length  = LEN_W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("beat_ready", 64'(p_ready), 64'd1);
        p_valid = 1'b1;
        p       = v;
        @(negedge clk);
        p_valid = 1'b0;
        p       = $urandom;
    endtask

    task automatic finish_run(input int hold, output logic [ACC_W-1:0] r, output logic o);
        int n;
        n = 0;
        while (!res_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) chk("res_valid_timeout", 64'd0, 64'd1);
        repeat (hold) begin
            res_ready = 1'b0;
            start     = 1'($urandom_range(1, 0));
            length    = LEN_W'($urandom);
            @(negedge clk);
        end
        r = result;
        o = ovf;
        // Start during the handshake cycle must be ignored.
        start     = 1'($urandom_range(1, 0));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic run(input int maxgap, input int hold, output logic [ACC_W-1:0] r, output logic o);
        start_run(beats.size());
        foreach (beats[i]) feed(beats[i], maxgap);
        chk("latency", 64'(res_valid), 64'd1);
        finish_run(hold, r, o);
    endtask

    function automatic logic [63:0] beat_sum();
        logic [63:0] s;
        s = '0;
        foreach (beats[i]) s += 64'(beats[i]);
        return s;
    endfunction

    initial begin
        logic [ACC_W-1:0] r;
        logic             o;
        int               len;
        int               cut;

        rst = 1'b1; start = 1'b0; length = '0; clear = 1'b0;
        p = '0; p_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        beats = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0005};
        run(0, 0, r, o);
        chk("three_beat_result", 64'(r), 64'h1_0001_0004);
        chk("three_beat_ovf", 64'(o), 64'd0);

        beats = {};
        run(0, 1, r, o);
        chk("len0_result", 64'(r), 64'd0);

        beats = {};
        repeat (16) beats.push_back(32'hFFFF_FFFF);
        run(0, 0, r, o);
        chk("len16_result", 64'(r), 64'hF_FFFF_FFF0);
        chk("len16_ovf", 64'(o), 64'd0);
        beats.push_back(32'hFFFF_FFFF);
        run(1, 0, r, o);
        chk("len17_result", 64'(r), 64'hF_FFFF_FFFF);
        chk("len17_ovf", 64'(o), 64'd1);

        beats = {};
        repeat (4) beats.push_back($urandom);
        run(3, 5, r, o);
        chk("gapped_result", 64'(r), sat(beat_sum()));

        start_run(4);
        feed($urandom, 1);
        feed($urandom, 1);
        clear = 1'b1; p_valid = 1'b1; p = $urandom;
        @(negedge clk);
        clear = 1'b0; p_valid = 1'b0;
        chk("clear_busy", 64'(busy), 64'd0);
        chk("clear_p_ready", 64'(p_ready), 64'd0);
        beats = '{32'd7};
        run(0, 0, r, o);
        chk("after_clear_result", 64'(r), 64'd7);

        start_run(2);
        feed($urandom, 0);
        feed($urandom, 0);
        chk("pre_rst_done", 64'(res_valid), 64'd1);
        res_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_res_valid", 64'(res_valid), 64'd0);
        chk("rst_done_result", 64'(result), 64'd0);
        chk("rst_done_busy", 64'(busy), 64'd0);

        for (int k = 0; k < 30; k++) begin
            beats = {};
            len = (k % 5 == 4) ? int'($urandom_range(40, 15)) : int'($urandom_range(20, 0));
            for (int b = 0; b < len; b++)
                beats.push_back((k % 5 == 4) ? 32'hFFFF_FFFF - 32'($urandom_range(3, 0)) : $urandom);
            if (k % 7 == 3 && len > 1) begin
                cut = int'($urandom_range(len - 1, 1));
                start_run(len);
                for (int b = 0; b < cut; b++) feed(beats[b], 2);
                clear = 1'b1; p_valid = 1'($urandom_range(1, 0));
                @(negedge clk);
                clear = 1'b0; p_valid = 1'b0;
            end else begin
                run(3, int'($urandom_range(4, 0)), r, o);
                chk("rand_result", 64'(r), sat(beat_sum()));
                chk("rand_ovf", 64'(o), 64'(beat_sum() > MAXV));
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
